rop_blend_multadd_pipe: RTL

Parametrised successor to the ROP fixed-function blend multiply-add unit. Computes src_color*src_factor (op) dst_color*dst_factor per channel, then clamps and normalises back to channel width. Generalised in channel width and count, adds MIN/MAX blend modes, pipelines the modes with the data, and adds a valid/ready handshake with backpressure and a passthrough tag. Sits between the ROP blend-factor stage and the ROP output-merge stage.

---
 rtl/rop_blend_multadd_pipe.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/rop_blend_multadd_pipe.sv
// Blend multiply-add: per channel src*sf (op) dst*df, clamp, normalise to N bits; MIN/MAX on raw colour.
// Latency: 3 cycles from accept to valid_out; 1 pixel/cycle when not stalled.
// Backpressure: global stall; every stage holds while valid_out && !ready_out, and ready_in follows.
module rop_blend_multadd_pipe #(
  parameter int CHANNEL_BITS = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int TAG_WIDTH    = 1
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 valid_in,
  output logic                                 ready_in,
  input  logic [2:0]                           mode_rgb,
  input  logic [2:0]                           mode_a,
  input  logic [NUM_CHANNELS*CHANNEL_BITS-1:0] src_color,
  input  logic [NUM_CHANNELS*CHANNEL_BITS-1:0] dst_color,
  input  logic [NUM_CHANNELS*CHANNEL_BITS-1:0] src_factor,
  input  logic [NUM_CHANNELS*CHANNEL_BITS-1:0] dst_factor,
  input  logic [TAG_WIDTH-1:0]                 tag_in,
  output logic                                 valid_out,
  input  logic                                 ready_out,
  output logic [NUM_CHANNELS*CHANNEL_BITS-1:0] color_out,
  output logic [TAG_WIDTH-1:0]                 tag_out
);

  localparam int N = CHANNEL_BITS;
  localparam int C = NUM_CHANNELS;
  // Signed sum width: one bit of headroom for ps+pd, one for the sign.
  localparam int W = 2*N + 2;

  localparam logic [2:0] MODE_ADD     = 3'd0;
  localparam logic [2:0] MODE_SUB     = 3'd1;
  localparam logic [2:0] MODE_REV_SUB = 3'd2;
  localparam logic [2:0] MODE_MIN     = 3'd3;
  localparam logic [2:0] MODE_MAX     = 3'd4;

  localparam logic [W-1:0] RND   = W'(1) << (N-1);
  localparam logic [W-1:0] CLAMP = W'({N{1'b1}}) << N;

  // The top channel is alpha and follows its own mode.
  function automatic logic [2:0] sel_mode(input int ch, input logic [2:0] rgb, input logic [2:0] alpha);
    return (ch == C-1) ? alpha : rgb;
  endfunction

  logic advance;

  // Stage 1: products plus raw colours for MIN/MAX
  logic                   s1_vld;
  logic [2:0]             s1_mode_rgb, s1_mode_a;
  logic [TAG_WIDTH-1:0]   s1_tag;
  logic [C-1:0][2*N-1:0]  s1_ps, s1_pd;
  logic [C-1:0][N-1:0]    s1_src, s1_dst;
  logic [C-1:0][2*N-1:0]  ps_c, pd_c;

  // Stage 2: rounded signed sums
  logic                   s2_vld;
  logic [2:0]             s2_mode_rgb, s2_mode_a;
  logic [TAG_WIDTH-1:0]   s2_tag;
  logic [C-1:0][W-1:0]    s2_sum;
  logic [C-1:0][N-1:0]    s2_src, s2_dst;
  logic [C-1:0][W-1:0]    sum_c;

  // Stage 3: final channel results
  logic                   s3_vld;
  logic [TAG_WIDTH-1:0]   s3_tag;
  logic [C*N-1:0]         s3_color;
  logic [C-1:0][2*N-1:0]  clamp_c, norm_c;
  logic [C-1:0][N-1:0]    res_c;

  assign advance   = !s3_vld || ready_out;
  assign ready_in  = advance;
  assign valid_out = s3_vld;
  assign color_out = s3_color;
  assign tag_out   = s3_tag;

  // Per-channel unsigned products, operands zero-extended to the full product width.
  always_comb begin
    ps_c = '0;
    pd_c = '0;
    for (int i = 0; i < C; i++) begin
      ps_c[i] = {{N{1'b0}}, src_color[i*N +: N]} * {{N{1'b0}}, src_factor[i*N +: N]};
      pd_c[i] = {{N{1'b0}}, dst_color[i*N +: N]} * {{N{1'b0}}, dst_factor[i*N +: N]};
    end
  end

  // Stage 1 register: a bubble enters whenever valid_in is low on an advancing cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld      <= 1'b0;
      s1_mode_rgb <= '0;
      s1_mode_a   <= '0;
      s1_tag      <= '0;
      s1_ps       <= '0;
      s1_pd       <= '0;
      s1_src      <= '0;
      s1_dst      <= '0;
    end else if (advance) begin
      s1_vld      <= valid_in;
      s1_mode_rgb <= mode_rgb;
      s1_mode_a   <= mode_a;
      s1_tag      <= tag_in;
      s1_ps       <= ps_c;
      s1_pd       <= pd_c;
      s1_src      <= src_color;
      s1_dst      <= dst_color;
    end
  end

  // Add/subtract with the rounding constant; MIN/MAX/reserved do not use the sum.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < C; i++) begin
      case (sel_mode(i, s1_mode_rgb, s1_mode_a))
        MODE_ADD:     sum_c[i] = {2'b00, s1_ps[i]} + {2'b00, s1_pd[i]} + RND;
        MODE_SUB:     sum_c[i] = {2'b00, s1_ps[i]} - {2'b00, s1_pd[i]} + RND;
        MODE_REV_SUB: sum_c[i] = {2'b00, s1_pd[i]} - {2'b00, s1_ps[i]} + RND;
        default:      sum_c[i] = '0;
      endcase
    end
  end

  // Stage 2 register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_vld      <= 1'b0;
      s2_mode_rgb <= '0;
      s2_mode_a   <= '0;
      s2_tag      <= '0;
      s2_sum      <= '0;
      s2_src      <= '0;
      s2_dst      <= '0;
    end else if (advance) begin
      s2_vld      <= s1_vld;
      s2_mode_rgb <= s1_mode_rgb;
      s2_mode_a   <= s1_mode_a;
      s2_tag      <= s1_tag;
      s2_sum      <= sum_c;
      s2_src      <= s1_src;
      s2_dst      <= s1_dst;
    end
  end

  // Clamp to [0, M<<N], fold back to N bits with (c + c>>N) >> N, or pick MIN/MAX.
  always_comb begin
    clamp_c = '0;
    norm_c  = '0;
    res_c   = '0;
    for (int i = 0; i < C; i++) begin
      if (s2_sum[i][W-1])
        clamp_c[i] = '0;
      else if (s2_sum[i] > CLAMP)
        clamp_c[i] = CLAMP[2*N-1:0];
      else
        clamp_c[i] = s2_sum[i][2*N-1:0];
      norm_c[i] = clamp_c[i] + (clamp_c[i] >> N);
      case (sel_mode(i, s2_mode_rgb, s2_mode_a))
        MODE_ADD, MODE_SUB, MODE_REV_SUB: res_c[i] = norm_c[i][2*N-1:N];
        MODE_MIN: res_c[i] = (s2_src[i] < s2_dst[i]) ? s2_src[i] : s2_dst[i];
        MODE_MAX: res_c[i] = (s2_src[i] > s2_dst[i]) ? s2_src[i] : s2_dst[i];
        default:  res_c[i] = '0;
      endcase
    end
  end

  // Stage 3 register drives the outputs directly; held stable while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s3_vld   <= 1'b0;
      s3_tag   <= '0;
      s3_color <= '0;
    end else if (advance) begin
      s3_vld   <= s2_vld;
      s3_tag   <= s2_tag;
      s3_color <= res_c;
    end
  end

endmodule
